// File: rtl/sprite_ram_writer.sv
// Sprite attribute RAM write side: CPU writes to the sprite windows are queued in a
// small FIFO and committed one per cycle whenever the vblank fetch FSM is not reading.
module sprite_ram_writer #(
  parameter int unsigned DEPTH         = 4,
  parameter logic [15:0] SPRITE_OFFSET = 16'h4FF0,
  parameter logic [15:0] X_OFFSET      = 16'h5060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_wr_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wr_data,
  output logic        cpu_ready,
  output logic        overflow,
  input  logic        fetch_busy,
  output logic [15:0] sprite_RAM_addr,
  output logic [7:0]  sprite_RAM_dout,
  output logic        wr_en,
  output logic        pending
);

  localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  logic [23:0]   mem_q [DEPTH];
  logic [23:0]   mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [1:0]    cs_q, cs_d;

  logic in_range;
  logic push;
  logic pop;

  always_comb begin
    in_range = ((cpu_addr >= SPRITE_OFFSET) && (cpu_addr <= SPRITE_OFFSET + 16'd15)) ||
               ((cpu_addr >= X_OFFSET)      && (cpu_addr <= X_OFFSET + 16'd15));
    cpu_ready = (count_q < DEPTH_C);
    pending   = (count_q != {CW{1'b0}});
    // The fetch FSM wins the RAM in the very cycle it asserts fetch_busy.
    wr_en     = ((cs_q == DRAIN) || (cs_q == STALL)) && !fetch_busy;
    pop       = wr_en;
    push      = cpu_wr_en && in_range && cpu_ready;

    if (wr_en) begin
      sprite_RAM_addr = mem_q[head_q][23:8];
      sprite_RAM_dout = mem_q[head_q][7:0];
    end else begin
      sprite_RAM_addr = 16'h0000;
      sprite_RAM_dout = 8'h00;
    end
    overflow = overflow_q;
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[tail_q] = {cpu_addr, cpu_wr_data};
    end else begin
      mem_d[tail_q] = mem_q[tail_q];
    end
    tail_d     = push ? tail_q + AW'(1) : tail_q;
    head_d     = pop  ? head_q + AW'(1) : head_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    // A full FIFO rejects the write even if the head pops this same cycle.
    overflow_d = cpu_wr_en && in_range && !cpu_ready;
  end

  always_comb begin
    cs_d = cs_q;
    case (cs_q)
      IDLE:         cs_d = push ? (fetch_busy ? STALL : DRAIN) : IDLE;
      DRAIN, STALL: cs_d = (count_d == {CW{1'b0}}) ? IDLE : (fetch_busy ? STALL : DRAIN);
      default:      cs_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 24'h000000;
      end
      head_q     <= {AW{1'b0}};
      tail_q     <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
      cs_q       <= IDLE;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      cs_q       <= cs_d;
    end
  end

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Bench for sprite_ram_writer: table-driven decode/commit vectors plus hand sequences,
// with a scoreboard queue checked against every RAM write the DUT issues.
module tb_sprite_ram_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_wr_en = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wr_data = 8'h00;
  logic        cpu_ready;
  logic        overflow;
  logic        fetch_busy = 1'b0;
  logic [15:0] sprite_RAM_addr;
  logic [7:0]  sprite_RAM_dout;
  logic        wr_en;
  logic        pending;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } ent_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        fb;
    logic        exp_in;
  } vec_t;

  ent_t exp_q[$];
  ent_t mon_e;
  vec_t vecs[12];

  sprite_ram_writer dut (
    .clk(clk), .rst(rst), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_ready(cpu_ready), .overflow(overflow),
    .fetch_busy(fetch_busy), .sprite_RAM_addr(sprite_RAM_addr),
    .sprite_RAM_dout(sprite_RAM_dout), .wr_en(wr_en), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Drive one cycle of inputs just after the edge, then let combinational outputs settle.
  task automatic drive(input logic we, input logic [15:0] a, input logic [7:0] d, input logic fb);
    @(posedge clk);
    #1;
    cpu_wr_en   = we;
    cpu_addr    = a;
    cpu_wr_data = d;
    fetch_busy  = fb;
    #1;
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Scoreboard: every RAM write must match the oldest outstanding accepted CPU write.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wr_en", {16'h0, sprite_RAM_addr}, 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ram_addr", {16'h0, sprite_RAM_addr}, {16'h0, mon_e.a});
          chk("ram_dout", {24'h0, sprite_RAM_dout}, {24'h0, mon_e.d});
        end
      end else begin
        chk("idle_addr_dout", {8'h0, sprite_RAM_addr, sprite_RAM_dout}, 32'h0);
      end
      if (fetch_busy) chk("no_wr_while_busy", {31'h0, wr_en}, 32'h0);
    end
  end

  initial begin
    int n;

    vecs[0]  = '{addr: 16'h4FEF, data: 8'h11, fb: 1'b0, exp_in: 1'b0};
    vecs[1]  = '{addr: 16'h4FF0, data: 8'h22, fb: 1'b0, exp_in: 1'b1};
    vecs[2]  = '{addr: 16'h4FFF, data: 8'h33, fb: 1'b0, exp_in: 1'b1};
    vecs[3]  = '{addr: 16'h5000, data: 8'h44, fb: 1'b1, exp_in: 1'b0};
    vecs[4]  = '{addr: 16'h505F, data: 8'h55, fb: 1'b0, exp_in: 1'b0};
    vecs[5]  = '{addr: 16'h5060, data: 8'h66, fb: 1'b0, exp_in: 1'b1};
    vecs[6]  = '{addr: 16'h506F, data: 8'h77, fb: 1'b0, exp_in: 1'b1};
    vecs[7]  = '{addr: 16'h5070, data: 8'h88, fb: 1'b1, exp_in: 1'b0};
    vecs[8]  = '{addr: 16'h4FF5, data: 8'hA1, fb: 1'b0, exp_in: 1'b1};
    vecs[9]  = '{addr: 16'h4FF5, data: 8'hA2, fb: 1'b0, exp_in: 1'b1};
    vecs[10] = '{addr: 16'h0000, data: 8'h99, fb: 1'b0, exp_in: 1'b0};
    vecs[11] = '{addr: 16'hFFFF, data: 8'hBB, fb: 1'b0, exp_in: 1'b0};

    // Reset state
    #12;
    chk("rst_ready", {31'h0, cpu_ready}, 32'h1);
    chk("rst_pending", {31'h0, pending}, 32'h0);
    chk("rst_wr_en", {31'h0, wr_en}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_addr_dout", {8'h0, sprite_RAM_addr, sprite_RAM_dout}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single write, one-cycle latency, no bypass
    drive(1'b1, 16'h4FF2, 8'h3C, 1'b0);
    push_exp(16'h4FF2, 8'h3C);
    chk("t1_no_bypass", {31'h0, wr_en}, 32'h0);
    drive(1'b0, 16'h0, 8'h0, 1'b0);
    chk("t1_wr_en", {31'h0, wr_en}, 32'h1);
    chk("t1_addr", {16'h0, sprite_RAM_addr}, 32'h4FF2);
    chk("t1_dout", {24'h0, sprite_RAM_dout}, 32'h3C);
    drive(1'b0, 16'h0, 8'h0, 1'b0);
    chk("t1_pending", {31'h0, pending}, 32'h0);
    chk("t1_wr_en_off", {31'h0, wr_en}, 32'h0);

    // Table-driven decode boundaries, duplicates, streaming commits
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].addr, vecs[i].data, vecs[i].fb);
      if (vecs[i].exp_in) push_exp(vecs[i].addr, vecs[i].data);
      chk("vec_ready", {31'h0, cpu_ready}, 32'h1);
      chk("vec_overflow", {31'h0, overflow}, 32'h0);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 16'h0, 8'h0, 1'b0);
    chk("vec_drained", exp_q.size(), 32'h0);
    chk("vec_pending", {31'h0, pending}, 32'h0);

    // Fill while busy, overflow on 5th, then drain 4 back-to-back
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h5060 + 16'(i), 8'(i + 1), 1'b1);
      push_exp(16'h5060 + 16'(i), 8'(i + 1));
      chk("t3_ready_before", {31'h0, cpu_ready}, 32'h1);
    end
    drive(1'b1, 16'h5064, 8'h05, 1'b1);
    chk("t3_ready_full", {31'h0, cpu_ready}, 32'h0);
    chk("t3_no_early_ovf", {31'h0, overflow}, 32'h0);
    drive(1'b0, 16'h0, 8'h0, 1'b1);
    chk("t3_overflow", {31'h0, overflow}, 32'h1);
    drive(1'b0, 16'h0, 8'h0, 1'b1);
    chk("t3_overflow_pulse", {31'h0, overflow}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h0, 8'h0, 1'b0);
      chk("t3_drain_wr_en", {31'h0, wr_en}, 32'h1);
    end
    drive(1'b0, 16'h0, 8'h0, 1'b0);
    chk("t3_pending", {31'h0, pending}, 32'h0);

    // Stall in the middle of draining
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h4FF8 + 16'(i), 8'hC0 + 8'(i), 1'b1);
      push_exp(16'h4FF8 + 16'(i), 8'hC0 + 8'(i));
    end
    drive(1'b0, 16'h0, 8'h0, 1'b0);
    chk("t4_first_pop", {31'h0, wr_en}, 32'h1);
    drive(1'b0, 16'h0, 8'h0, 1'b1);
    chk("t4_stall_same_cycle", {31'h0, wr_en}, 32'h0);
    chk("t4_stall_pending", {31'h0, pending}, 32'h1);
    drive(1'b0, 16'h0, 8'h0, 1'b1);
    drive(1'b0, 16'h0, 8'h0, 1'b0);
    chk("t4_resume", {31'h0, wr_en}, 32'h1);
    drive(1'b0, 16'h0, 8'h0, 1'b0);
    chk("t4_resume2", {31'h0, wr_en}, 32'h1);
    drive(1'b0, 16'h0, 8'h0, 1'b0);
    chk("t4_done", {31'h0, pending}, 32'h0);

    // Full FIFO: pop and push in the same cycle drops the push
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h5068 + 16'(i), 8'hD0 + 8'(i), 1'b1);
      push_exp(16'h5068 + 16'(i), 8'hD0 + 8'(i));
    end
    drive(1'b1, 16'h506C, 8'hEE, 1'b0);
    n = wr_en ? 1 : 0;
    chk("t5_ready_full", {31'h0, cpu_ready}, 32'h0);
    drive(1'b0, 16'h0, 8'h0, 1'b0);
    chk("t5_overflow", {31'h0, overflow}, 32'h1);
    chk("t5_ready_after", {31'h0, cpu_ready}, 32'h1);
    for (int k = 0; k < 10; k++) begin
      if (!wr_en) break;
      n++;
      drive(1'b0, 16'h0, 8'h0, 1'b0);
    end
    chk("t5_commit_count", n, 32'd4);
    chk("t5_pending", {31'h0, pending}, 32'h0);

    // Asynchronous reset with entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h4FF0 + 16'(i), 8'h70 + 8'(i), 1'b1);
      push_exp(16'h4FF0 + 16'(i), 8'h70 + 8'(i));
    end
    drive(1'b0, 16'h0, 8'h0, 1'b1);
    chk("t6_pending_before", {31'h0, pending}, 32'h1);
    fetch_busy = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_pending", {31'h0, pending}, 32'h0);
    chk("t6_ready", {31'h0, cpu_ready}, 32'h1);
    chk("t6_wr_en", {31'h0, wr_en}, 32'h0);
    chk("t6_addr_dout", {8'h0, sprite_RAM_addr, sprite_RAM_dout}, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h0, 8'h0, 1'b0);
      chk("t6_no_wr_after", {31'h0, wr_en}, 32'h0);
    end
    chk("final_queue_empty", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
